// File: rtl/pll_pkg.sv
// Shared types and default parameters for the PLL reconfiguration sequencer.
package pll_pkg;

    localparam int unsigned DefDivW         = 8;
    localparam int unsigned DefSettleCycles = 16;
    localparam int unsigned DefLockTimeout  = 1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BYPASS    = 3'd1,
        PRST      = 3'd2,
        WAIT_LOCK = 3'd3,
        UNBYP     = 3'd4,
        ERR       = 3'd5
    } pll_seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Runs one full PLL reprogram per accepted start: bypass, reset, load dividers,
// wait for stable lock (with timeout), un-bypass; reports busy/done/err.
module pll_reconfig_sequencer
    import pll_pkg::*;
#(
    parameter int unsigned       DIV_W         = DefDivW,
    parameter logic [DIV_W-1:0]  DEF_M         = DIV_W'(1),
    parameter logic [DIV_W-1:0]  DEF_N         = DIV_W'(1),
    parameter int unsigned       SETTLE_CYCLES = DefSettleCycles,
    parameter int unsigned       LOCK_TIMEOUT  = DefLockTimeout
) (
    input  logic             i_clk_ahb,
    input  logic             i_rst_ahb,
    input  logic             i_start,
    input  logic [DIV_W-1:0] i_div_m,
    input  logic [DIV_W-1:0] i_div_n,
    input  logic             i_pll_lock,
    output logic             o_pll_rst,
    output logic             o_pll_bypass,
    output logic [DIV_W-1:0] o_div_m,
    output logic [DIV_W-1:0] o_div_n,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int unsigned CntW      = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CntW-1:0] SettleCnt = CntW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0] TmoCnt    = CntW'(LOCK_TIMEOUT);

    pll_seq_state_t   state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CntW-1:0]  stab_q, stab_d, stab_inc;
    logic [CntW-1:0]  tmo_q, tmo_d, tmo_inc;
    logic             pll_rst_q, pll_rst_d;
    logic             bypass_q, bypass_d;
    logic [DIV_W-1:0] div_m_q, div_m_d;
    logic [DIV_W-1:0] div_n_q, div_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             lock_s;
    logic             start_acc;

    sync_2ff u_lock_sync (
        .clk_i (i_clk_ahb),
        .rst_i (i_rst_ahb),
        .d_i   (i_pll_lock),
        .q_o   (lock_s)
    );

    assign start_acc = (state_q == IDLE) && i_start;

    // Saturating increments; transitions compare the count including the current cycle.
    assign cnt_inc  = (cnt_q  == '1) ? cnt_q  : cnt_q  + 1'b1;
    assign stab_inc = (stab_q == '1) ? stab_q : stab_q + 1'b1;
    assign tmo_inc  = (tmo_q  == '1) ? tmo_q  : tmo_q  + 1'b1;

    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stab_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stab_q  <= stab_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_start) state_d = BYPASS;
            BYPASS:    if (cnt_inc == SettleCnt) state_d = PRST;
            PRST:      if (cnt_inc == SettleCnt) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s && (stab_inc == SettleCnt)) begin
                    state_d = UNBYP;
                end else if (tmo_inc == TmoCnt) begin
                    state_d = ERR;
                end
            end
            UNBYP:     if (cnt_inc == SettleCnt) state_d = IDLE;
            ERR:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = '0;
        stab_d = '0;
        tmo_d  = '0;
        if (state_d == state_q) begin
            if (state_q inside {BYPASS, PRST, UNBYP}) begin
                cnt_d = cnt_inc;
            end
            if (state_q == WAIT_LOCK) begin
                tmo_d  = tmo_inc;
                stab_d = lock_s ? stab_inc : '0;
            end
        end
    end

    // Output registers take their value from the state being entered.
    always_comb begin
        pll_rst_d = pll_rst_q;
        bypass_d  = bypass_q;
        div_m_d   = div_m_q;
        div_n_d   = div_n_q;
        err_d     = err_q;
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == UNBYP) && (state_d == IDLE);
        if (start_acc) begin
            div_m_d = i_div_m;
            div_n_d = i_div_n;
            err_d   = 1'b0;
        end
        case (state_d)
            BYPASS:    bypass_d = 1'b1;
            PRST: begin
                pll_rst_d = 1'b1;
                bypass_d  = 1'b1;
            end
            WAIT_LOCK: begin
                pll_rst_d = 1'b0;
                bypass_d  = 1'b1;
            end
            UNBYP:     bypass_d = 1'b0;
            ERR: begin
                err_d     = 1'b1;
                pll_rst_d = 1'b1;
                bypass_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            pll_rst_q <= 1'b1;
            bypass_q  <= 1'b1;
            div_m_q   <= DEF_M;
            div_n_q   <= DEF_N;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pll_rst_q <= pll_rst_d;
            bypass_q  <= bypass_d;
            div_m_q   <= div_m_d;
            div_n_q   <= div_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_pll_rst    = pll_rst_q;
    assign o_pll_bypass = bypass_q;
    assign o_div_m      = div_m_q;
    assign o_div_n      = div_n_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench: each start pushes its expected completion event (done or err) with
// the cycle it must appear on; a monitor pops and compares when the DUT reports it.
module tb_pll_reconfig_sequencer;

    localparam int unsigned Settle = 4;
    localparam int unsigned Tmo    = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_div_m = 8'h00;
    logic [7:0] i_div_n = 8'h00;
    logic       i_pll_lock = 1'b0;
    logic       o_pll_rst, o_pll_bypass, o_busy, o_done, o_err;
    logic [7:0] o_div_m, o_div_n;

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [7:0] m;
        logic [7:0] n;
    } evt_t;

    evt_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic err_prev = 1'b0;

    pll_reconfig_sequencer #(
        .DIV_W         (8),
        .DEF_M         (8'd1),
        .DEF_N         (8'd1),
        .SETTLE_CYCLES (Settle),
        .LOCK_TIMEOUT  (Tmo)
    ) dut (
        .i_clk_ahb    (clk),
        .i_rst_ahb    (rst),
        .i_start      (i_start),
        .i_div_m      (i_div_m),
        .i_div_n      (i_div_n),
        .i_pll_lock   (i_pll_lock),
        .o_pll_rst    (o_pll_rst),
        .o_pll_bypass (o_pll_bypass),
        .o_div_m      (o_div_m),
        .o_div_n      (o_div_n),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_start(input logic [7:0] m, input logic [7:0] n, output int t0);
        t0      = cyc;
        i_start = 1'b1;
        i_div_m = m;
        i_div_n = n;
        tick();
        i_start = 1'b0;
        i_div_m = 8'hEE;
        i_div_n = 8'hEE;
    endtask

    task automatic push_evt(input bit is_err, input int at, input logic [7:0] m,
                            input logic [7:0] n);
        evt_t e;
        e.is_err = is_err;
        e.cyc    = at;
        e.m      = m;
        e.n      = n;
        sb.push_back(e);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) tick();
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic handle_evt(input bit is_err);
        evt_t e;
        if (sb.size() == 0) begin
            check(is_err ? "unexpected_err" : "unexpected_done", 1, 0);
        end else begin
            e = sb.pop_front();
            check("evt_kind", is_err, e.is_err);
            check("evt_cycle", cyc, e.cyc);
            check("evt_div_m", o_div_m, e.m);
            check("evt_div_n", o_div_n, e.n);
            check("evt_bypass", o_pll_bypass, is_err ? 1 : 0);
            check("evt_pll_rst", o_pll_rst, is_err ? 1 : 0);
            check("evt_busy", o_busy, is_err ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_done) handle_evt(1'b0);
            if (o_err && !err_prev) handle_evt(1'b1);
        end
        err_prev <= o_err;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"}, o_pll_rst, 1);
        check({tag, "_bypass"}, o_pll_bypass, 1);
        check({tag, "_div_m"}, o_div_m, 1);
        check({tag, "_div_n"}, o_div_n, 1);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_err"}, o_err, 0);
    endtask

    initial begin
        int t0;
        int pat[7] = '{1, 1, 0, 1, 1, 1, 1};

        // 1. Reset values, then idle with no start.
        #1 rst = 1'b1;
        #1 check_reset_vals("rst");
        tick(); tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        check_reset_vals("idle");

        // 2. Normal sequence, lock rises 3 cycles after pll_rst falls.
        do_start(8'd10, 8'd2, t0);
        push_evt(1'b0, t0 + 22, 8'd10, 8'd2);
        check("t2_div_m_c1", o_div_m, 10);
        check("t2_div_n_c1", o_div_n, 2);
        check("t2_busy_c1", o_busy, 1);
        run_to(t0 + 8);
        check("t2_pll_rst_c8", o_pll_rst, 1);
        run_to(t0 + 9);
        check("t2_pll_rst_c9", o_pll_rst, 0);
        run_to(t0 + 12);
        i_pll_lock = 1'b1;
        drain(40);
        run_to(t0 + 23);
        check("t2_done_c23", o_done, 0);
        check("t2_bypass_after", o_pll_bypass, 0);

        // 3. Lock never arrives: timeout into ERR.
        i_pll_lock = 1'b0;
        repeat (3) tick();
        do_start(8'd5, 8'd3, t0);
        push_evt(1'b1, t0 + 9 + Tmo, 8'd5, 8'd3);
        drain(80);
        run_to(t0 + 10 + Tmo);
        check("t3_busy_idle", o_busy, 0);
        check("t3_err", o_err, 1);
        check("t3_bypass", o_pll_bypass, 1);
        check("t3_pll_rst", o_pll_rst, 1);
        repeat (4) tick();
        check("t3_err_sticky", o_err, 1);

        // 4. Lock glitch in WAIT_LOCK restarts the stable count; start clears err.
        check("t4_err_c0", o_err, 1);
        do_start(8'd33, 8'd44, t0);
        check("t4_err_c1", o_err, 0);
        push_evt(1'b0, t0 + 22, 8'd33, 8'd44);
        for (int k = 0; k < 7; k++) begin
            run_to(t0 + 9 + k);
            i_pll_lock = pat[k][0];
        end
        run_to(t0 + 17);
        check("t4_bypass_c17", o_pll_bypass, 1);
        run_to(t0 + 18);
        check("t4_bypass_c18", o_pll_bypass, 0);
        drain(40);

        // 5. Second start while busy is ignored.
        i_pll_lock = 1'b0;
        repeat (3) tick();
        do_start(8'd20, 8'd4, t0);
        push_evt(1'b0, t0 + 22, 8'd20, 8'd4);
        run_to(t0 + 6);
        i_start = 1'b1;
        i_div_m = 8'd99;
        i_div_n = 8'd99;
        tick();
        i_start = 1'b0;
        check("t5_div_m_c7", o_div_m, 20);
        check("t5_div_n_c7", o_div_n, 4);
        run_to(t0 + 12);
        i_pll_lock = 1'b1;
        drain(40);

        // 6. Async reset in WAIT_LOCK, then a clean full sequence.
        i_pll_lock = 1'b0;
        repeat (3) tick();
        do_start(8'd7, 8'd9, t0);
        run_to(t0 + 10);
        #2 rst = 1'b1;
        #1 check_reset_vals("t6_async");
        tick();
        rst = 1'b0;
        tick();
        check_reset_vals("t6_post");
        do_start(8'd3, 8'd6, t0);
        push_evt(1'b0, t0 + 22, 8'd3, 8'd6);
        run_to(t0 + 12);
        i_pll_lock = 1'b1;
        drain(40);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
